// File: rtl/rca_share_seq_if.sv
// Bundle between the requesting engines, the shared 32-bit ripple-carry adder
// and the result consumer of rca_share_seq.
interface rca_share_seq_if #(
  parameter int W = 32
);
  logic [1:0]   req_valid;
  logic [W-1:0] req_a0;
  logic [W-1:0] req_a1;
  logic [W-1:0] req_b0;
  logic [W-1:0] req_b1;
  logic [1:0]   req_sub;
  logic [1:0]   req_last;
  logic [1:0]   req_ready;

  logic [W-1:0] add_a;
  logic [W-1:0] add_b;
  logic         add_cin;
  logic [W-1:0] add_s;
  logic         add_cout;

  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] res_data;
  logic         res_id;
  logic         res_last;
  logic         res_cout;
  logic         res_ovf;
  logic         res_err;

  // Environment side: requesters, the adder instance and the result consumer.
  modport master (
    output req_valid, req_a0, req_a1, req_b0, req_b1, req_sub, req_last,
    input  req_ready,
    input  add_a, add_b, add_cin,
    output add_s, add_cout,
    input  res_valid, res_data, res_id, res_last, res_cout, res_ovf, res_err,
    output res_ready
  );

  modport slave (
    input  req_valid, req_a0, req_a1, req_b0, req_b1, req_sub, req_last,
    output req_ready,
    output add_a, add_b, add_cin,
    input  add_s, add_cout,
    output res_valid, res_data, res_id, res_last, res_cout, res_ovf, res_err,
    input  res_ready
  );
endinterface

// File: rtl/rca_share_seq.sv
// Shares one external ripple-carry adder between two requesters streaming
// multi-word add/subtract transactions, LS word first, with chained carry.
module rca_share_seq #(
  parameter int W         = 32,
  parameter int MAX_WORDS = 8,
  parameter int CNT_W     = 4
) (
  input logic           clk,
  input logic           rst_n,
  rca_share_seq_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  logic             carry_q;
  logic             sub_q;
  logic             rr_last;
  logic             owner_q;
  logic [CNT_W-1:0] cnt;

  logic             out_free;
  logic             owner;
  logic             has_req;
  logic             first;
  logic             sub;
  logic             accept;
  logic             terminal;
  logic [CNT_W-1:0] word_idx;
  logic [W-1:0]     op_a;
  logic [W-1:0]     op_b;
  logic [1:0]       ready;

  assign out_free = !bus.res_valid || bus.res_ready;
  assign first    = (state == IDLE);

  // In IDLE the owner is arbitrated afresh; a tie goes to whoever did not win last.
  always_comb begin
    owner   = owner_q;
    has_req = 1'b1;
    if (state == IDLE) begin
      case (bus.req_valid)
        2'b01:   owner = 1'b0;
        2'b10:   owner = 1'b1;
        2'b11:   owner = ~rr_last;
        default: begin
          owner   = 1'b0;
          has_req = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ready = 2'b00;
    if (rst_n && has_req && out_free) begin
      ready[owner] = 1'b1;
    end
  end

  assign bus.req_ready = ready;
  assign accept        = |(ready & bus.req_valid);

  assign sub      = first ? bus.req_sub[owner] : sub_q;
  assign op_a     = owner ? bus.req_a1 : bus.req_a0;
  assign op_b     = owner ? bus.req_b1 : bus.req_b0;
  assign word_idx = first ? '0 : cnt;
  assign terminal = bus.req_last[owner] || (word_idx == CNT_W'(MAX_WORDS - 1));

  assign bus.add_a   = op_a;
  assign bus.add_b   = sub ? ~op_b : op_b;
  assign bus.add_cin = first ? sub : carry_q;

  // Nothing but the output register and bookkeeping moves without an accepted word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      carry_q       <= 1'b0;
      sub_q         <= 1'b0;
      rr_last       <= 1'b1;
      owner_q       <= 1'b0;
      cnt           <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_id    <= 1'b0;
      bus.res_last  <= 1'b0;
      bus.res_cout  <= 1'b0;
      bus.res_ovf   <= 1'b0;
      bus.res_err   <= 1'b0;
    end else if (accept) begin
      carry_q       <= bus.add_cout;
      bus.res_valid <= 1'b1;
      bus.res_data  <= bus.add_s;
      bus.res_id    <= owner;
      bus.res_last  <= terminal;
      bus.res_cout  <= bus.add_cout;
      bus.res_ovf   <= (bus.add_a[W-1] == bus.add_b[W-1]) &&
                       (bus.add_s[W-1] != bus.add_a[W-1]);
      bus.res_err   <= terminal && !bus.req_last[owner];
      if (first) begin
        rr_last <= owner;
        owner_q <= owner;
        sub_q   <= bus.req_sub[owner];
      end
      if (terminal) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        state <= BUSY;
        cnt   <= first ? CNT_W'(1) : cnt + CNT_W'(1);
      end
    end else if (bus.res_ready) begin
      bus.res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rca_share_seq.sv
// Scoreboard bench for rca_share_seq: directed words push expected results,
// a monitor pops and compares whenever a result is consumed.
module tb_rca_share_seq;

  localparam int W = 32;

  typedef struct packed {
    logic [31:0] data;
    logic        id;
    logic        last;
    logic        cout;
    logic        ovf;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sbQ[$];

  logic        v0 = 0, v1 = 0, s0 = 0, s1 = 0, l0 = 0, l1 = 0;
  logic [31:0] a0 = 0, a1 = 0, b0 = 0, b1 = 0;
  logic        resReady = 1'b1;

  rca_share_seq_if #(.W(W)) bus ();

  rca_share_seq #(.W(W), .MAX_WORDS(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.req_valid = {v1, v0};
  assign bus.req_a0    = a0;
  assign bus.req_a1    = a1;
  assign bus.req_b0    = b0;
  assign bus.req_b1    = b1;
  assign bus.req_sub   = {s1, s0};
  assign bus.req_last  = {l1, l0};
  assign bus.res_ready = resReady;
  // The shared adder itself lives outside the block.
  assign {bus.add_cout, bus.add_s} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Present one word, wait for its acceptance, check the adder carry-in and queue the result.
  task automatic applyStimulus(input logic id, input logic [31:0] a, input logic [31:0] b,
                               input logic sub, input logic last, input logic cin,
                               input logic [31:0] expData, input logic expCout,
                               input logic expOvf, input logic expErr, output int accCyc);
    bit done = 0;
    accCyc = -1;
    if (id) begin a1 = a; b1 = b; s1 = sub; l1 = last; v1 = 1; end
    else    begin a0 = a; b0 = b; s0 = sub; l0 = last; v0 = 1; end
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        checkVal("add_cin", {31'd0, bus.add_cin}, {31'd0, cin});
        sbQ.push_back('{expData, id, last | expErr, expCout, expOvf, expErr});
        @(posedge clk);
        #1;
        done   = 1;
        accCyc = cyc;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: requester %0d got no ready, expected ready within 50 cycles", id);
    end
    if (id) v1 = 0; else v0 = 0;
  endtask

  // Monitor: every consumed result is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && bus.res_valid && bus.res_ready) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_result: got %h expected none", bus.res_data);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkVal("res_data", bus.res_data, e.data);
        checkVal("res_id",   {31'd0, bus.res_id},   {31'd0, e.id});
        checkVal("res_last", {31'd0, bus.res_last}, {31'd0, e.last});
        checkVal("res_cout", {31'd0, bus.res_cout}, {31'd0, e.cout});
        checkVal("res_ovf",  {31'd0, bus.res_ovf},  {31'd0, e.ovf});
        checkVal("res_err",  {31'd0, bus.res_err},  {31'd0, e.err});
      end
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checkVal(name, act, exp);
  endtask

  task automatic doReset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin
    int c0a, c0b, c0c, c1a, c1b, c1c, cx;

    // Reset state, with a requester already asserting valid.
    v0 = 1;
    rst_n = 0;
    @(negedge clk);
    checkVal("reset_res_valid", {31'd0, bus.res_valid}, 32'd0);
    checkVal("reset_req_ready", {30'd0, bus.req_ready}, 32'd0);
    v0 = 0;
    @(posedge clk);
    #1;
    rst_n = 1;

    // Single-word add with carry out, then a two-word add chaining the carry.
    applyStimulus(0, 32'hFFFFFFFF, 32'h1, 0, 1, 0, 32'h0, 1, 0, 0, cx);
    applyStimulus(1, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 32'h0, 1, 0, 0, cx);
    applyStimulus(1, 32'h0,        32'h0, 0, 1, 1, 32'h1, 0, 0, 0, cx);

    // Subtract: negative result, then signed overflow.
    applyStimulus(0, 32'h5,        32'h7, 1, 1, 1, 32'hFFFFFFFE, 0, 0, 0, cx);
    applyStimulus(0, 32'h80000000, 32'h1, 1, 1, 1, 32'h7FFFFFFF, 1, 1, 0, cx);

    // Contention after reset: req0 wins the tie and keeps the adder for its 3 words.
    repeat (2) @(posedge clk);
    doReset();
    fork
      begin
        applyStimulus(0, 32'd1, 32'd2, 0, 0, 0, 32'd3,  0, 0, 0, c0a);
        applyStimulus(0, 32'd3, 32'd4, 0, 0, 0, 32'd7,  0, 0, 0, c0b);
        applyStimulus(0, 32'd5, 32'd6, 0, 1, 0, 32'd11, 0, 0, 0, c0c);
      end
      begin
        applyStimulus(1, 32'd10, 32'd20, 0, 0, 0, 32'h1E, 0, 0, 0, c1a);
        applyStimulus(1, 32'd30, 32'd40, 0, 0, 0, 32'h46, 0, 0, 0, c1b);
        applyStimulus(1, 32'd50, 32'd60, 0, 1, 0, 32'h6E, 0, 0, 0, c1c);
      end
      begin
        @(negedge clk);
        checkVal("tie_ready", {30'd0, bus.req_ready}, 32'd1);
      end
    join
    checkOutput("req0_word2_cycle", c0b - c0a, 1);
    checkOutput("req0_word3_cycle", c0c - c0a, 2);
    checkOutput("req1_start_cycle", c1a - c0c, 1);
    checkOutput("req1_word3_cycle", c1c - c1a, 2);

    // A fresh tie after req1 finished goes back to req0.
    fork
      applyStimulus(0, 32'd100, 32'd1, 0, 1, 0, 32'd101, 0, 0, 0, c0a);
      applyStimulus(1, 32'd200, 32'd2, 0, 1, 0, 32'd202, 0, 0, 0, c1a);
    join
    checkOutput("second_tie_order", c1a - c0a, 1);

    // Backpressure mid-transaction: the held result stays put and the carry survives.
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 32'hFFFFFFFE, 1, 0, 0, cx);
    resReady = 0;
    fork
      applyStimulus(0, 32'h1, 32'h0, 0, 1, 1, 32'h2, 0, 0, 0, cx);
      begin
        repeat (3) begin
          @(negedge clk);
          checkVal("bp_req_ready", {30'd0, bus.req_ready}, 32'd0);
          checkVal("bp_res_valid", {31'd0, bus.res_valid}, 32'd1);
          checkVal("bp_res_data",  bus.res_data, 32'hFFFFFFFE);
          checkVal("bp_res_cout",  {31'd0, bus.res_cout}, 32'd1);
        end
        @(posedge clk);
        #1;
        resReady = 1;
      end
    join

    // Force termination at the 4th word, then a new subtract transaction starts with cin=sub.
    applyStimulus(1, 32'd1, 32'd1, 0, 0, 0, 32'd2, 0, 0, 0, cx);
    applyStimulus(1, 32'd2, 32'd2, 0, 0, 0, 32'd4, 0, 0, 0, cx);
    applyStimulus(1, 32'd3, 32'd3, 0, 0, 0, 32'd6, 0, 0, 0, cx);
    applyStimulus(1, 32'd4, 32'd4, 0, 0, 0, 32'd8, 0, 0, 1, cx);
    applyStimulus(1, 32'd10, 32'd3, 1, 1, 1, 32'd7, 1, 0, 0, cx);

    // Reset while a result is pending: it is dropped and the next word starts clean.
    repeat (2) @(posedge clk);
    #1;
    resReady = 0;
    applyStimulus(0, 32'hFFFFFFFF, 32'h1, 0, 0, 0, 32'h0, 1, 0, 0, cx);
    rst_n = 0;
    sbQ.delete();
    @(posedge clk);
    #1;
    rst_n = 1;
    checkVal("mid_reset_res_valid", {31'd0, bus.res_valid}, 32'd0);
    checkVal("mid_reset_req_ready", {30'd0, bus.req_ready}, 32'd0);
    resReady = 1;
    applyStimulus(0, 32'd5, 32'd6, 0, 1, 0, 32'd11, 0, 0, 0, cx);

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_empty", sbQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rca_share_seq.md
Name: rca_share_seq

Overview:
- Sequencer and arbiter that shares one external 32-bit ripple-carry adder between two requesters.
- Each requester streams a multi-word add/subtract transaction, one word per cycle, least-significant word first.
- The block drives the adder operands, chains carry between words, and returns registered per-word results with final carry and signed overflow.
- It sits between requesting engines and the single shared RCA32 instance.

Parameters:
- W, 32, word width; must match the adder width.
- MAX_WORDS, 8, maximum words per transaction; the MAX_WORDS-th word is force-terminated.
- CNT_W, 4, width of the word counter; must satisfy 2^CNT_W > MAX_WORDS.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- req_valid  in  2  per-requester word valid, bit i = requester i
- req_a0, req_a1  in  W  operand A word of requester 0 / 1
- req_b0, req_b1  in  W  operand B word of requester 0 / 1
- req_sub  in  2  subtract mode per requester; sampled on the first word only
- req_last  in  2  marks the final word of a transaction
- req_ready  out  2  word accepted when valid&ready
- add_a  out  W  to adder a
- add_b  out  W  to adder b; B or ~B
- add_cin  out  1  to adder cin
- add_s  in  W  adder sum; combinational from add_*
- add_cout  in  1  adder carry out
- res_valid  out  1  result word valid
- res_ready  in  1  downstream accepts result
- res_data  out  W  sum word
- res_id  out  1  owning requester
- res_last  out  1  final word of the transaction
- res_cout  out  1  carry out; meaningful when res_last=1
- res_ovf  out  1  signed overflow of the full-width result; meaningful when res_last=1
- res_err  out  1  transaction force-terminated at MAX_WORDS

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; carry_q=0; sub_q=0; cnt=0.
  - rr_last=1, so requester 0 wins the first tie.
  - All res_* outputs and req_ready are 0.
  - Reset mid-transaction abandons it; a pending result is dropped.
- Output register:
  - One entry. out_free = !res_valid || res_ready.
  - The register loads the cycle after a word is accepted, giving 1-cycle latency.
  - res_valid clears when res_ready is high and no new word is accepted.
  - While res_valid=1 and res_ready=0, all res_* outputs hold stable.
- States:
  - IDLE: owner is chosen combinationally.
    - Exactly one req_valid bit set: that requester is owner.
    - Both set: owner = ~rr_last.
    - Neither set: no owner; req_ready=0.
    - req_ready[owner] = out_free.
    - On acceptance: rr_last<=owner; owner_q<=owner; sub_q<=req_sub[owner]; cnt<=1.
    - If the accepted word is terminal, stay IDLE; else go to BUSY.
  - BUSY: only owner_q may be granted.
    - req_ready[owner_q] = out_free; the other requester's ready=0.
    - A word is terminal when req_last=1 or cnt==MAX_WORDS-1.
    - A terminal word returns the block to IDLE, and the next transaction can be accepted the following cycle (no bubble).
    - Non-terminal word: cnt<=cnt+1.
- Adder drive (combinational, from the current owner's word):
  - add_a = A.
  - add_b = sub ? ~B : B.
  - add_cin = first word ? sub : carry_q.
  - sub = req_sub[owner] in IDLE, sub_q in BUSY.
  - carry_q<=add_cout only on acceptance.
  - With no acceptance, carry_q and cnt are unchanged (backpressure safe).
- Result fields (loaded on acceptance):
  - res_data=add_s; res_cout=add_cout; res_id=owner.
  - res_last=terminal.
  - res_err = terminal && !req_last.
  - res_ovf = (add_a[W-1]==add_b[W-1]) && (add_s[W-1]!=add_a[W-1]).
- Source rules:
  - A requester must hold its valid and data stable until ready.
  - Dropping valid mid-transaction stalls the block in BUSY; no timeout.
  - Words from the non-owner are never accepted, whatever their valid.

Test Plan:
- Single-word add: req0 A=FFFFFFFF, B=00000001, last=1, sub=0 -> next cycle res_data=00000000, res_cout=1, res_last=1, res_id=0, res_err=0.
- 64-bit add: req1 words (FFFFFFFF,00000001) then (00000000,00000000, last=1) -> results 00000000 then 00000001, final res_cout=0; the carry chains correctly.
- Subtract:
  - sub=1, A=5, B=7 -> res_data=FFFFFFFE, res_cout=0, res_ovf=0.
  - sub=1, A=80000000, B=1 -> res_data=7FFFFFFF, res_ovf=1.
- Contention after reset: both requesters present 3-word transactions -> req0 owns 3 consecutive cycles, req_ready[1]=0 throughout; req1 is accepted the cycle after req0's last word; a new tie then goes to req0.
- Backpressure: hold res_ready=0 for 3 cycles mid-transaction -> req_ready=0, res_* held stable, carry_q unchanged; results resume correct when res_ready=1.
- MAX_WORDS=4, req_last never set -> 4th result has res_last=1, res_err=1; the 5th word starts a new transaction with add_cin=sub.
- Reset mid-transaction -> next cycle res_valid=0, state IDLE, add_cin=0 on the next accepted add word.
